// File: rtl/ultrasonido_pkg.sv
// Shared definitions for the ultrasonic sensor emulator and its measurement controller.
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  localparam int CLK_HZ          = 50_000_000;
  localparam int CYCLES_PER_CM   = 2920;
  localparam int TRIG_MIN_CYCLES = 500;
  localparam int MAX_CM          = 400;

endpackage

// File: rtl/ultrasonic_echo_responder_trigger_sync.sv
// Two-flop synchronizer with registered rise/fall pulses aligned to the synchronized level.
module trigger_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, rise_q, fall_q;

  // Edge pulses are formed from the stage pair so they assert on the same edge as level_o.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      rise_q <= s1_q & ~s2_q;
      fall_q <= ~s1_q & s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Emulates the HC-SR04 sensor: validates the trigger width, waits the burst delay,
// then drives an echo whose width encodes the programmed distance.
module ultrasonic_echo_responder
  import ultrasonido_pkg::*;
#(
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int BURST_CYCLES    = 10000,
  parameter int CYCLES_PER_CM   = 2920,
  parameter int MAX_CM          = 400,
  parameter int TIMEOUT_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES  = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic       trig_ignored
);

  localparam int MAX_PROD = MAX_CM * CYCLES_PER_CM;
  localparam int MAX_A    = (MAX_PROD > TIMEOUT_CYCLES) ? MAX_PROD : TIMEOUT_CYCLES;
  localparam int MAX_B    = (MAX_A > BURST_CYCLES) ? MAX_A : BURST_CYCLES;
  localparam int MAX_C    = (MAX_B > HOLDOFF_CYCLES) ? MAX_B : HOLDOFF_CYCLES;
  localparam int CNT_W    = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_TRIG_CYCLES);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_L  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CPCM       = CNT_W'(CYCLES_PER_CM);

  // Zero and beyond-range distances answer with the sensor's no-object pulse.
  function automatic logic [CNT_W-1:0] echo_len(input logic [8:0] cm);
    if (cm != 9'd0 && cm <= 9'(MAX_CM)) echo_len = CNT_W'(cm) * CPCM;
    else                                echo_len = TIMEOUT_L;
  endfunction

  logic ts, ts_rise, ts_fall;

  trigger_sync u_trigger_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (trigger),
    .level_o (ts),
    .rise_o  (ts_rise),
    .fall_o  (ts_fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             echo_q, echo_d, busy_q, busy_d;
  logic             err_q, err_d, ign_q, ign_d;
  logic             latch;
  logic [8:0]       cm_q;
  logic [CNT_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ign_q   <= ign_d;
    end
  end

  // Length is computed once, on the first BURST cycle, from the freshly latched distance.
  always_ff @(posedge clk) begin
    if (latch) cm_q <= distance_cm;
    if (state_q == BURST && cnt_q == '0) len_q <= echo_len(cm_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    echo_d  = echo_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    ign_d   = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ts_rise) begin
          state_d = TRIG_HIGH;
          cnt_d   = ONE;
        end
      end
      TRIG_HIGH: begin
        if (ts_fall) begin
          cnt_d = '0;
          if (cnt_q >= MIN_C) begin
            state_d = BURST;
            busy_d  = 1'b1;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (ts && cnt_q < MIN_C) begin
          cnt_d = cnt_q + ONE;
        end
      end
      BURST: begin
        ign_d = ts_rise;
        if (cnt_q == BURST_LAST) begin
          state_d = ECHO;
          cnt_d   = '0;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ECHO: begin
        ign_d = ts_rise;
        if (cnt_q == len_q - ONE) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          echo_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HOLDOFF: begin
        ign_d = ts_rise;
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign echo         = echo_q;
  assign busy         = busy_q;
  assign trig_err     = err_q;
  assign trig_ignored = ign_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for the ultrasonic echo responder using reduced timing parameters.
module tb_ultrasonic_echo_responder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distance_cm = 9'd0;
  logic       echo, busy, trig_err, trig_ignored;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int echo_rise_at = 0, echo_fall_at = 0, busy_rise_at = 0, busy_fall_at = 0;
  int err_at = 0, ign_at = 0;
  int n_echo_rise = 0, n_echo_fall = 0, nb_rise = 0, nb_fall = 0, n_err = 0, n_ign = 0;
  logic echo_prev = 1'b0, busy_prev = 1'b0;

  ultrasonic_echo_responder #(
    .MIN_TRIG_CYCLES (5),
    .BURST_CYCLES    (10),
    .CYCLES_PER_CM   (4),
    .MAX_CM          (20),
    .TIMEOUT_CYCLES  (100),
    .HOLDOFF_CYCLES  (20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .distance_cm  (distance_cm),
    .echo         (echo),
    .busy         (busy),
    .trig_err     (trig_err),
    .trig_ignored (trig_ignored)
  );

  always #5 clk = ~clk;

  // Event recorder: cycle index of each output edge, plus high-cycle counts of the pulses.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (echo === 1'b1 && !echo_prev) begin echo_rise_at = cyc; n_echo_rise++; end
    if (echo !== 1'b1 && echo_prev)  begin echo_fall_at = cyc; n_echo_fall++; end
    if (busy === 1'b1 && !busy_prev) begin busy_rise_at = cyc; nb_rise++; end
    if (busy !== 1'b1 && busy_prev)  begin busy_fall_at = cyc; nb_fall++; end
    if (trig_err === 1'b1)     begin err_at = cyc; n_err++; end
    if (trig_ignored === 1'b1) begin ign_at = cyc; n_ign++; end
    echo_prev = (echo === 1'b1);
    busy_prev = (busy === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic drive_trig(input int n, output int c1);
    @(negedge clk);
    trigger = 1'b1;
    c1 = cyc + 1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_busy_fall(input int limit, output bit ok);
    int start;
    start = nb_fall;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (nb_fall != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_echo_edge(input bit rise, input int limit, output bit ok);
    int start;
    start = rise ? n_echo_rise : n_echo_fall;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((rise ? n_echo_rise : n_echo_fall) != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b expected 0", echo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (trig_err !== 1'b0) begin errors++; $display("FAIL reset_trig_err: got %b expected 0", trig_err); end
    checks++; if (trig_ignored !== 1'b0) begin errors++; $display("FAIL reset_trig_ignored: got %b expected 0", trig_ignored); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int c1; bit ok; int r0; int e0;
    r0 = n_echo_rise; e0 = n_err;
    distance_cm = 9'd10;
    drive_trig(8, c1);
    wait_busy_fall(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: busy never fell, got 0 expected 1"); end
    checks++; if (busy_rise_at != c1 + 10) begin errors++; $display("FAIL basic_busy_rise: got cycle %0d expected %0d", busy_rise_at, c1 + 10); end
    checks++; if (echo_rise_at - busy_rise_at != 10) begin errors++; $display("FAIL basic_burst: got %0d expected 10", echo_rise_at - busy_rise_at); end
    checks++; if (echo_fall_at - echo_rise_at != 40) begin errors++; $display("FAIL basic_echo_width: got %0d expected 40", echo_fall_at - echo_rise_at); end
    checks++; if (busy_fall_at - echo_fall_at != 20) begin errors++; $display("FAIL basic_holdoff: got %0d expected 20", busy_fall_at - echo_fall_at); end
    checks++; if (n_echo_rise - r0 != 1) begin errors++; $display("FAIL basic_echo_count: got %0d expected 1", n_echo_rise - r0); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL basic_no_err: got %0d expected 0", n_err - e0); end
  endtask

  task automatic test_short_trigger();
    int widths[2] = '{3, 4};
    int c1; int e0; int b0; int r0;
    foreach (widths[k]) begin
      e0 = n_err; b0 = nb_rise; r0 = n_echo_rise;
      distance_cm = 9'd10;
      drive_trig(widths[k], c1);
      repeat (30) @(negedge clk);
      checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL short%0d_err_cycles: got %0d expected 1", widths[k], n_err - e0); end
      checks++; if (err_at != c1 + widths[k] + 2) begin errors++; $display("FAIL short%0d_err_time: got %0d expected %0d", widths[k], err_at, c1 + widths[k] + 2); end
      checks++; if (nb_rise - b0 != 0) begin errors++; $display("FAIL short%0d_busy: got %0d expected 0", widths[k], nb_rise - b0); end
      checks++; if (n_echo_rise - r0 != 0) begin errors++; $display("FAIL short%0d_echo: got %0d expected 0", widths[k], n_echo_rise - r0); end
    end
  endtask

  task automatic test_range();
    int cms[4]  = '{0, 25, 21, 1};
    int exps[4] = '{100, 100, 100, 4};
    int c1; bit ok;
    foreach (cms[k]) begin
      distance_cm = 9'(cms[k]);
      drive_trig(8, c1);
      wait_busy_fall(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL range%0d_done: got 0 expected 1", cms[k]); end
      checks++; if (echo_fall_at - echo_rise_at != exps[k]) begin errors++; $display("FAIL range%0d_width: got %0d expected %0d", cms[k], echo_fall_at - echo_rise_at, exps[k]); end
    end
  endtask

  task automatic test_ignored();
    int c1; int c2; bit ok; bit ok2; int r0; int i0;
    r0 = n_echo_rise; i0 = n_ign;
    distance_cm = 9'd10;
    drive_trig(8, c1);
    wait_echo_edge(1'b1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_echo_start: got 0 expected 1"); end
    repeat (5) @(negedge clk);
    distance_cm = 9'd3;
    drive_trig(8, c2);
    wait_busy_fall(400, ok2);
    checks++; if (!ok2) begin errors++; $display("FAIL ign_done: got 0 expected 1"); end
    checks++; if (n_ign - i0 != 1) begin errors++; $display("FAIL ign_pulse_cycles: got %0d expected 1", n_ign - i0); end
    checks++; if (ign_at != c2 + 2) begin errors++; $display("FAIL ign_pulse_time: got %0d expected %0d", ign_at, c2 + 2); end
    checks++; if (echo_fall_at - echo_rise_at != 40) begin errors++; $display("FAIL ign_echo_width: got %0d expected 40", echo_fall_at - echo_rise_at); end
    repeat (40) @(negedge clk);
    checks++; if (n_echo_rise - r0 != 1) begin errors++; $display("FAIL ign_echo_count: got %0d expected 1", n_echo_rise - r0); end
  endtask

  task automatic test_reset_mid_echo();
    int c1; bit ok;
    distance_cm = 9'd10;
    drive_trig(8, c1);
    wait_echo_edge(1'b1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_echo_start: got 0 expected 1"); end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo: got %b expected 0", echo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    distance_cm = 9'd2;
    drive_trig(8, c1);
    wait_busy_fall(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_after_done: got 0 expected 1"); end
    checks++; if (busy_rise_at != c1 + 10) begin errors++; $display("FAIL rst_after_busy_rise: got %0d expected %0d", busy_rise_at, c1 + 10); end
    checks++; if (echo_fall_at - echo_rise_at != 8) begin errors++; $display("FAIL rst_after_width: got %0d expected 8", echo_fall_at - echo_rise_at); end
  endtask

  task automatic test_held_high();
    int b0; int r0; int e0; bit ok;
    b0 = nb_rise; r0 = n_echo_rise; e0 = n_err;
    distance_cm = 9'd5;
    @(negedge clk);
    trigger = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (nb_rise - b0 != 0) begin errors++; $display("FAIL held_busy: got %0d expected 0", nb_rise - b0); end
    checks++; if (n_echo_rise - r0 != 0) begin errors++; $display("FAIL held_echo: got %0d expected 0", n_echo_rise - r0); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL held_err: got %0d expected 0", n_err - e0); end
    trigger = 1'b0;
    wait_busy_fall(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_release_done: got 0 expected 1"); end
    checks++; if (echo_fall_at - echo_rise_at != 20) begin errors++; $display("FAIL held_release_width: got %0d expected 20", echo_fall_at - echo_rise_at); end
  endtask

  task automatic test_back_to_back();
    int c1; int c2; int c3; bit ok; bit ok2; bit ok3; int i0; int b0;
    distance_cm = 9'd20;
    drive_trig(5, c1);
    wait_echo_edge(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_echo: got 0 expected 1"); end
    checks++; if (busy_rise_at != c1 + 7) begin errors++; $display("FAIL b2b_min_accept: got %0d expected %0d", busy_rise_at, c1 + 7); end
    checks++; if (echo_fall_at - echo_rise_at != 80) begin errors++; $display("FAIL b2b_first_width: got %0d expected 80", echo_fall_at - echo_rise_at); end
    repeat (3) @(negedge clk);
    i0 = n_ign; b0 = nb_rise;
    distance_cm = 9'd7;
    drive_trig(8, c2);
    wait_busy_fall(100, ok2);
    checks++; if (!ok2) begin errors++; $display("FAIL b2b_holdoff_done: got 0 expected 1"); end
    checks++; if (n_ign - i0 != 1 || ign_at != c2 + 2) begin errors++; $display("FAIL b2b_ignored: got %0d pulses at %0d expected 1 at %0d", n_ign - i0, ign_at, c2 + 2); end
    repeat (20) @(negedge clk);
    checks++; if (nb_rise - b0 != 0) begin errors++; $display("FAIL b2b_no_restart: got %0d expected 0", nb_rise - b0); end
    drive_trig(6, c3);
    wait_busy_fall(400, ok3);
    checks++; if (!ok3) begin errors++; $display("FAIL b2b_second_done: got 0 expected 1"); end
    checks++; if (busy_rise_at != c3 + 8) begin errors++; $display("FAIL b2b_second_busy_rise: got %0d expected %0d", busy_rise_at, c3 + 8); end
    checks++; if (echo_fall_at - echo_rise_at != 28) begin errors++; $display("FAIL b2b_second_width: got %0d expected 28", echo_fall_at - echo_rise_at); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_trigger();
    test_range();
    test_ignored();
    test_reset_mid_echo();
    test_held_high();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
Emulates the sensor end of the HC-SR04 trigger/echo protocol for hardware-in-loop and simulation testing of the ultrasonic measurement controller. It accepts a trigger pulse and validates its width. After a fixed burst delay, it drives an echo pulse whose width encodes a programmable distance. Out-of-range distances produce the sensor's no-object timeout pulse. It sits on the FPGA fabric in place of the physical sensor, with distance supplied from switches or a testbench.

Parameters:
MIN_TRIG_CYCLES, 500, minimum valid trigger high width in clk cycles (10 us at 50 MHz)
BURST_CYCLES, 10000, delay from accepted trigger fall to echo rise (200 us, 8x40 kHz burst)
CYCLES_PER_CM, 2920, echo-high cycles per centimetre (round trip at 343 m/s, 50 MHz)
MAX_CM, 400, largest distance answered with a proportional echo
TIMEOUT_CYCLES, 1900000, echo width when distance is out of range (38 ms)
HOLDOFF_CYCLES, 50000, dead time after echo fall before a new trigger is accepted

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  synchronous, active-low reset
trigger  input  1  trigger from controller; asynchronous, synchronized internally
distance_cm  input  9  emulated distance in cm, sampled at trigger acceptance
echo  output  1  echo pulse to controller, registered
busy  output  1  high from accepted trigger fall until holdoff ends
trig_err  output  1  one-cycle pulse: trigger fell before MIN_TRIG_CYCLES
trig_ignored  output  1  one-cycle pulse: trigger rise seen while busy

Behaviour:
- Reset: on a clk edge with reset_n=0, state=IDLE; all counters are 0; echo, busy, trig_err and trig_ignored are 0. Reset mid-echo drops echo on the next edge.
- Trigger path: 2-flop synchronizer followed by a registered edge detector. The protocol is defined on the synchronized signal ts. Rise/fall are seen 2 cycles after the pin changes.
- Cycle counter width: $clog2(max(MAX_CM*CYCLES_PER_CM, TIMEOUT_CYCLES, BURST_CYCLES, HOLDOFF_CYCLES)+1).
- States and transitions:
  - IDLE:
    - Rise of ts -> TRIG_HIGH, with the width counter cleared to 1.
  - TRIG_HIGH:
    - Counts while ts=1; the counter saturates at MIN_TRIG_CYCLES.
    - On fall with count >= MIN_TRIG_CYCLES: latch distance_cm, compute the echo length, set busy -> BURST.
    - On fall with count < MIN_TRIG_CYCLES: pulse trig_err -> IDLE.
  - BURST:
    - Counts BURST_CYCLES cycles -> ECHO.
    - echo rises on the edge where ECHO is entered, i.e. exactly BURST_CYCLES cycles after the edge where BURST was entered.
  - ECHO:
    - echo=1 for exactly L cycles, where L = latched_cm*CYCLES_PER_CM if 1 <= latched_cm <= MAX_CM, else TIMEOUT_CYCLES (covers 0 and >MAX_CM).
    - Then echo=0 -> HOLDOFF.
  - HOLDOFF:
    - Counts HOLDOFF_CYCLES cycles, clears busy -> IDLE.
- Arithmetic:
  - The product latched_cm*CYCLES_PER_CM is computed once, in the cycle after latch, into a registered length, before BURST counting matters. BURST_CYCLES >= 2 is required.
  - No overflow is permitted: the counter width above covers the maximum product.
- Boundaries:
  - Trigger rises during BURST/ECHO/HOLDOFF: pulse trig_ignored, no state change, and the latched distance is unchanged.
  - distance_cm changing after latch has no effect on the current echo.
  - Trigger held high indefinitely: remain in TRIG_HIGH and emit no echo.
  - Trigger exactly MIN_TRIG_CYCLES wide (synchronized): accepted.
  - A trigger rise in the same cycle HOLDOFF completes is ignored. Only rises seen in IDLE start a measurement.

Decomposition:
- Package ultrasonido_pkg holds:
  - State encoding: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
  - Shared constants, also used by the controller: CLK_HZ=50_000_000, CYCLES_PER_CM=2920, TRIG_MIN_CYCLES=500, MAX_CM=400.
- One sub-module: trigger_sync. It contains the 2-flop synchronizer plus registered rise/fall pulse outputs and is reusable for the echo input on the controller side.

Test Plan:
Use reduced parameters: MIN_TRIG_CYCLES=5, BURST_CYCLES=10, CYCLES_PER_CM=4, MAX_CM=20, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=20.
1. distance_cm=10, trigger high 8 cycles -> busy asserted, echo high exactly 40 cycles starting 10 cycles after BURST entry, busy low 20 cycles after echo fall.
2. Trigger high 3 cycles -> trig_err pulses once for 1 cycle; echo and busy stay 0.
3. distance_cm=0, then separately distance_cm=25 -> echo high exactly 100 cycles in each case.
4. During echo of a distance_cm=10 measurement, pulse trigger for 8 cycles and change distance_cm to 3 -> trig_ignored pulses once, echo width stays 40, no second echo.
5. Assert reset_n=0 for 1 cycle mid-echo -> echo=0 and busy=0 on that edge; the next valid trigger with distance_cm=2 gives an 8-cycle echo.
6. Trigger exactly 5 synchronized cycles with distance_cm=20 -> accepted, echo 80 cycles; back-to-back trigger during HOLDOFF -> trig_ignored, accepted only after return to IDLE.
